muldiv_ctrl: RTL
================

// Module: muldiv_ctrl
// PURPOSE
// - Sequences the multi-cycle multiply/divide unit and owns the HI/LO registers.
// - Sits beside the E stage. The E stage issues start/op/operands.
// - The Hazard unit ORs stall_md into its D-stage stall, which freezes IF/D and flushes D/E.
// - Models real MIPS mult/div latency so that mfhi/mflo and back-to-back md ops wait correctly.
// PARAMETERS
// - MULT_CYCLES  5   cycles busy is high for MULT/MULTU (and MADD/MSUB); legal range 1..15
// - DIV_CYCLES   10  cycles busy is high for DIV/DIVU; legal range 1..15
// PORTS
// - clk       in   1   system clock, rising edge
// - reset     in   1   asynchronous, active-high; clears all state
// - start     in   1   E stage holds an md instruction this cycle (one-cycle pulse per instr)
// - op        in   3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
// - src_a     in   32  rs value after E-stage forwarding
// - src_b     in   32  rt value after E-stage forwarding
// - md_use_D  in   1   D-stage instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo(/madd/msub)
// - busy      out  1   an operation is in progress
// - stall_md  out  1   stall request to Hazard
// - done      out  1   one-cycle pulse in the cycle HI/LO take a new mult/div result
// - hi        out  32  architectural HI
// - lo        out  32  architectural LO
// BEHAVIOUR
// - Reset: state IDLE, cnt=0, busy=0, done=0, hi=0, lo=0, pending regs=0.
// - Reset is honoured mid-operation: the operation is aborted and no HI/LO write occurs.
// - FSM IDLE:
//   - start with op MULT/MULTU/DIV/DIVU/(MADD/MSUB): latch the result into pend_hi/pend_lo.
//   - Load cnt with MULT_CYCLES or DIV_CYCLES, then go to BUSY.
//   - start with MTHI/MTLO: hi<=src_a (resp. lo<=src_a) at that edge; stay IDLE.
// - FSM BUSY:
//   - busy=1 for exactly N cycles, starting the cycle after start.
//   - cnt decrements every cycle.
//   - At the edge where cnt==1: hi<=pend_hi, lo<=pend_lo, done=1 for the following cycle, go to IDLE.
//   - The result is visible on hi/lo in the first cycle busy=0.
// - Arithmetic:
//   - MULT: {hi,lo} = signed(a)*signed(b), 64 bit.
//   - MULTU: {hi,lo} = unsigned 64-bit product.
//   - DIV: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
//   - DIVU: unsigned quotient and remainder.
//   - DIV 0x80000000 / -1: lo=0x80000000, hi=0.
//   - Divide by zero (b==0): still busy DIV_CYCLES; hi/lo left unchanged; done still pulses.
// - stall_md = md_use_D & (busy | start). It is combinational, with no registered delay.
//   - This covers an md instr in D following an md instr in E.
// - start while busy=1: ignored, with no effect on state, hi or lo.
//   - The Hazard stall prevents this, so it is an error case; the bench asserts it never occurs.
// - start with MTHI/MTLO while busy: also ignored.
// - Simultaneous completion and new start: cannot occur, because busy=1 in the completion cycle.
// - Outputs change only on clk or reset edges, except stall_md.
// CONFIGURATION
// - Macro MULDIV_MADD_EN.
// - Defined:
//   - op 110 MADD: {hi,lo} <= {hi,lo} + signed(a)*signed(b).
//   - op 111 MSUB: {hi,lo} <= {hi,lo} - signed(a)*signed(b).
//   - Both are sequenced with MULT_CYCLES.
//   - The accumulate base is the hi/lo value at start.
// - Not defined:
//   - ops 110/111 are treated as NOP: no busy, no hi/lo change.
//   - md_use_D decoding of them is the caller's concern.
// TESTING
// - MULT a=-3 (0xFFFFFFFD), b=7:
//   - busy is high for 5 cycles; done pulses once.
//   - Then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
// - DIV a=-7, b=2:
//   - busy is high for 10 cycles.
//   - Then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//   - DIVU 7/2 then gives lo=3, hi=1.
// - MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles:
//   - hi and lo update on the next edges; busy stays 0.
// - DIV with b=0 after hi=5, lo=6:
//   - busy is high for 10 cycles.
//   - hi=5 and lo=6 are unchanged.
// - MULTU 0xFFFFFFFF*0xFFFFFFFF with md_use_D=1 (mflo in D):
//   - stall_md=1 from the start cycle through the last busy cycle.
//   - stall_md=0 in the first cycle after busy falls.
//   - Result: hi=0xFFFFFFFE, lo=0x00000001.
// - Assert reset in the 3rd cycle of a MULT:
//   - busy=0, hi=0 and lo=0 immediately.
//   - No done pulse occurs afterwards.
//   - With MULDIV_MADD_EN defined: MADD 2*3 onto hi=0, lo=10 gives lo=16.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
//   Sequencer for the multi-cycle multiply/divide unit. It owns the
//   architectural HI/LO registers. The result of a mult/div is computed when
//   the operation starts and held in pending registers. It is committed to
//   HI/LO only after the modelled MIPS latency, so mfhi/mflo and back-to-back
//   md instructions see the correct stall behaviour.
//
//   Optional feature: define MULDIV_MADD_EN to enable MADD (op 110) and MSUB
//   (op 111) as signed multiply-accumulate onto {hi,lo}. Without the macro,
//   both opcodes are NOPs.
//
// Parameters
//   MULT_CYCLES  busy length for MULT/MULTU/MADD/MSUB (1..15)
//   DIV_CYCLES   busy length for DIV/DIVU (1..15)
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset, clears all state
//   start     in   one-cycle pulse: E stage holds an md instruction
//   op        in   3-bit md opcode (MULT/MULTU/DIV/DIVU/MTHI/MTLO/MADD/MSUB)
//   src_a     in   forwarded rs value
//   src_b     in   forwarded rt value
//   md_use_D  in   D-stage instruction uses the md unit or HI/LO
//   busy      out  operation in progress (registered)
//   stall_md  out  combinational stall request to the Hazard unit
//   done      out  one-cycle pulse while a new mult/div result first shows
//   hi        out  architectural HI
//   lo        out  architectural LO
// ---------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MADD  = 3'b110,
        OP_MSUB  = 3'b111
    } op_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;

    op_t         op_q;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [63:0] res;
    logic        seq_op;
    logic [3:0]  seq_len;

    assign op_q = op_t'(op);

    // Sign-extending to 64 bits makes the low 64 bits of the product the
    // correct two's-complement signed result.
    assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    assign prod_u = {32'd0, src_a} * {32'd0, src_b};

    // Signed division by magnitudes: this gives truncation toward zero and a
    // remainder with the dividend's sign. 0x80000000 / -1 wraps back to
    // 0x80000000 with remainder 0 and needs no special case.
    assign abs_a = src_a[31] ? (32'd0 - src_a) : src_a;
    assign abs_b = src_b[31] ? (32'd0 - src_b) : src_b;
    assign mag_q = abs_a / abs_b;
    assign mag_r = abs_a % abs_b;
    assign quo_s = (src_a[31] ^ src_b[31]) ? (32'd0 - mag_q) : mag_q;
    assign rem_s = src_a[31] ? (32'd0 - mag_r) : mag_r;

    // Result to latch at start. A divide by zero latches the current HI/LO,
    // so the commit at the end leaves the registers unchanged.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        res     = {hi, lo};
        seq_op  = 1'b0;
        seq_len = 4'(MULT_CYCLES);
        case (op_q)
            OP_MULT: begin
                res    = prod_s;
                seq_op = 1'b1;
            end
            OP_MULTU: begin
                res    = prod_u;
                seq_op = 1'b1;
            end
            OP_DIV: begin
                if (src_b != 32'd0) res = {rem_s, quo_s};
                seq_op  = 1'b1;
                seq_len = 4'(DIV_CYCLES);
            end
            OP_DIVU: begin
                if (src_b != 32'd0) res = {src_a % src_b, src_a / src_b};
                seq_op  = 1'b1;
                seq_len = 4'(DIV_CYCLES);
            end
`ifdef MULDIV_MADD_EN
            OP_MADD: begin
                res    = {hi, lo} + prod_s;
                seq_op = 1'b1;
            end
            OP_MSUB: begin
                res    = {hi, lo} - prod_s;
                seq_op = 1'b1;
            end
`else
            OP_MADD, OP_MSUB: ;
`endif
            default: ;
        endcase
    end

    // Combinational so an md instruction in D behind one in E is held
    // in the very cycle the E-stage op starts.
    assign stall_md = md_use_D & (busy | start);

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the pending result registers are reset with everything else,
        // so an aborted operation leaves no stale value behind.
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // read in this block sees the pre-edge value.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (seq_op) begin
                            {pend_hi, pend_lo} <= res;
                            cnt   <= seq_len;
                            busy  <= 1'b1;
                            state <= BUSY;
                        end else if (op_q == OP_MTHI) begin
                            hi <= src_a;
                        end else if (op_q == OP_MTLO) begin
                            lo <= src_a;
                        end
                    end
                end
                BUSY: begin
                    // A start arriving while busy is ignored here.
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        hi    <= pend_hi;
                        lo    <= pend_lo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
